// File: rtl/hilo_mdu_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encodings, FSM states, result payload.
package hilo_mdu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DIV_ITER = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/hilo_mdu_div_core.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
// Only built when HILO_MDU_DIV_EN is defined.
`ifdef HILO_MDU_DIV_EN
module hilo_mdu_div_core
  import hilo_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done_c,
  output logic [XLEN-1:0] quo_c,
  output logic [XLEN-1:0] rem_c
);

  logic            active_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   shift;
  logic [XLEN:0]   diff;
  logic            ge;

  // One restoring step; the final step's values feed the top directly on done_c.
  always_comb begin
    shift  = {rem_q, quo_q[XLEN-1]};
    diff   = shift - {1'b0, dsr_q};
    ge     = ~diff[XLEN];
    rem_c  = ge ? diff[XLEN-1:0] : shift[XLEN-1:0];
    quo_c  = {quo_q[XLEN-2:0], ge};
    done_c = active_q && (cnt_q == 6'(DIV_ITER - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= dividend;
      dsr_q    <= divisor;
    end else if (abort) begin
      active_q <= 1'b0;
    end else if (active_q) begin
      rem_q <= rem_c;
      quo_q <= quo_c;
      cnt_q <= cnt_q + 6'd1;
      if (done_c) active_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/hilo_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing one HI/LO write pulse per operation.
// Divider present only when HILO_MDU_DIV_EN is defined; otherwise divides write zero.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             hi_we_o,
  output logic             lo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, req_op;
  logic [WIDTH-1:0] a_q, b_q;
  hilo_t            result_q, res_d;
  logic             accept, load_res;
  logic             mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  assign req_op = mdu_op_e'(op_i);

  // Single 64x64 multiplier; sign-extending the operands yields the signed low 64 bits.
  always_comb begin
    mul_signed = (op_q == MDU_MULT);
    ext_a      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
    ext_b      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
    prod       = ext_a * ext_b;
  end

`ifdef HILO_MDU_DIV_EN
  logic             div_start, div_abort, div_done_c, req_signed, div_signed;
  logic [WIDTH-1:0] abs_a, abs_b, quo_c, rem_c;
  hilo_t            div_res;

  always_comb begin
    req_signed = (req_op == MDU_DIV);
    abs_a      = cond_neg(src_a_i, req_signed & src_a_i[WIDTH-1]);
    abs_b      = cond_neg(src_b_i, req_signed & src_b_i[WIDTH-1]);
    div_signed = (op_q == MDU_DIV);
    div_res.lo = cond_neg(quo_c, div_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]));
    div_res.hi = cond_neg(rem_c, div_signed & a_q[WIDTH-1]);
  end

  hilo_mdu_div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done_c   (div_done_c),
    .quo_c    (quo_c),
    .rem_c    (rem_c)
  );
`endif

  // Next state, result capture and the combinational stall / write strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_res = 1'b0;
    res_d    = '0;
    stall_o  = 1'b0;
    hi_we_o  = 1'b0;
    lo_we_o  = 1'b0;
`ifdef HILO_MDU_DIV_EN
    div_start = 1'b0;
    div_abort = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (op_valid_i && !flush_i) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          case (req_op)
            MDU_MULT, MDU_MULTU: state_d = MUL;
            default: begin
`ifdef HILO_MDU_DIV_EN
              if (src_b_i == '0) begin
                state_d  = DONE;
                load_res = 1'b1;
                res_d    = '{hi: src_a_i, lo: '1};
              end else begin
                state_d   = DIV;
                div_start = 1'b1;
              end
`else
              state_d  = DONE;
              load_res = 1'b1;
`endif
            end
          endcase
        end
      end
      MUL: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          load_res = 1'b1;
          res_d    = hilo_t'(prod);
        end
      end
      DIV: begin
        stall_o = 1'b1;
`ifdef HILO_MDU_DIV_EN
        if (flush_i) begin
          state_d   = IDLE;
          div_abort = 1'b1;
        end else if (div_done_c) begin
          state_d  = DONE;
          load_res = 1'b1;
          res_d    = div_res;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
        hi_we_o = !flush_i;
        lo_we_o = !flush_i;
      end
    endcase
    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MDU_MULT;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= req_op;
        a_q  <= src_a_i;
        b_q  <= src_b_i;
      end
      if (load_res) result_q <= res_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign hi_o   = result_q.hi;
  assign lo_o   = result_q.lo;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu; divide checks follow HILO_MDU_DIV_EN.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, hi_we_o, lo_we_o;
  logic [31:0] hi_o, lo_o;

  int          total = 0;
  int          bad = 0;
  int          lat, stalls;
  logic [31:0] rh, rl;
  logic        rlw;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid_i (op_valid_i),
    .op_i       (op_i),
    .src_a_i    (src_a_i),
    .src_b_i    (src_b_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .hi_we_o    (hi_we_o),
    .lo_we_o    (lo_we_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Issue a request in the current cycle, then wait (bounded) for the write pulse.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int s, output logic [31:0] h,
                        output logic [31:0] lw_val, output logic lwe);
    l = -1; s = 0; h = '0; lw_val = '0; lwe = 1'b0;
    op_valid_i = 1'b1; op_i = o; src_a_i = a; src_b_i = b;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (hi_we_o) begin
        l = c; h = hi_o; lw_val = lo_o; lwe = lo_we_o;
        break;
      end
      if (stall_o) s++;
      next_cycle();
      op_valid_i = 1'b0;
      #1;
    end
    op_valid_i = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_stall", stall_o, 1'b0);
    check1("rst_hi_we", hi_we_o, 1'b0);
    check32("rst_hi", hi_o, 32'h0);
    check32("rst_lo", lo_o, 32'h0);
    #9 rst = 1'b0;
    next_cycle(); #1;
    check1("idle_busy", busy_o, 1'b0);

    // MULT -2 * 3
    next_cycle();
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, lat, stalls, rh, rl, rlw);
    check32("mult_lat", 32'(lat), 32'd2);
    check32("mult_stalls", 32'(stalls), 32'd2);
    check32("mult_hi", rh, 32'hFFFF_FFFF);
    check32("mult_lo", rl, 32'hFFFF_FFFA);
    check1("mult_lo_we", rlw, 1'b1);
    next_cycle(); #1;
    check1("post_we", hi_we_o, 1'b0);
    check1("post_busy", busy_o, 1'b0);
    check32("hold_hi", hi_o, 32'hFFFF_FFFF);

    // MULTU back-to-back, accepted the cycle after DONE
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, rh, rl, rlw);
    check32("multu_lat", 32'(lat), 32'd2);
    check32("multu_hi", rh, 32'hFFFF_FFFE);
    check32("multu_lo", rl, 32'h0000_0001);

    // Request with flush in IDLE is ignored
    next_cycle();
    op_valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; src_a_i = 32'd9; src_b_i = 32'd9;
    #1;
    check1("idle_flush_stall", stall_o, 1'b0);
    next_cycle();
    op_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    check1("idle_flush_busy", busy_o, 1'b0);

    // Flush during MUL: no pulse, results untouched
    op_valid_i = 1'b1; op_i = 2'b00; src_a_i = 32'd5; src_b_i = 32'd5;
    #1;
    next_cycle();
    op_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    check1("mulflush_busy", busy_o, 1'b1);
    check1("mulflush_stall", stall_o, 1'b1);
    check1("mulflush_we", hi_we_o, 1'b0);
    next_cycle();
    flush_i = 1'b0;
    #1;
    check1("mulflush_idle", busy_o, 1'b0);
    check1("mulflush_we2", hi_we_o, 1'b0);
    check32("mulflush_hold", hi_o, 32'hFFFF_FFFE);

    // Flush arriving in DONE masks the pulse combinationally
    op_valid_i = 1'b1; op_i = 2'b00; src_a_i = 32'd2; src_b_i = 32'd3;
    #1;
    next_cycle();
    op_valid_i = 1'b0;
    next_cycle();
    flush_i = 1'b1;
    #1;
    check1("doneflush_hi_we", hi_we_o, 1'b0);
    check1("doneflush_lo_we", lo_we_o, 1'b0);
    check1("doneflush_stall", stall_o, 1'b0);
    flush_i = 1'b0;
    #1;
    check1("done_we", hi_we_o, 1'b1);
    check32("done_lo", lo_o, 32'd6);

`ifdef HILO_MDU_DIV_EN
    next_cycle();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, stalls, rh, rl, rlw);
    check32("div_lat", 32'(lat), 32'd33);
    check32("div_stalls", 32'(stalls), 32'd33);
    check32("div_lo", rl, 32'hFFFF_FFFD);
    check32("div_hi", rh, 32'hFFFF_FFFF);

    next_cycle();
    run_op(2'b11, 32'd100, 32'd7, lat, stalls, rh, rl, rlw);
    check32("divu_lat", 32'(lat), 32'd33);
    check32("divu_lo", rl, 32'd14);
    check32("divu_hi", rh, 32'd2);

    next_cycle();
    run_op(2'b10, 32'd5, 32'd0, lat, stalls, rh, rl, rlw);
    check32("div0_lat", 32'(lat), 32'd1);
    check32("div0_stalls", 32'(stalls), 32'd1);
    check32("div0_hi", rh, 32'd5);
    check32("div0_lo", rl, 32'hFFFF_FFFF);

    next_cycle();
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls, rh, rl, rlw);
    check32("divovf_lo", rl, 32'h8000_0000);
    check32("divovf_hi", rh, 32'h0);

    // DIVU flushed at N+10
    next_cycle();
    op_valid_i = 1'b1; op_i = 2'b11; src_a_i = 32'd1000; src_b_i = 32'd3;
    #1;
    rlw = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      op_valid_i = 1'b0;
      #1;
      rlw = rlw | hi_we_o;
    end
    check1("divflush_nopulse", rlw, 1'b0);
    flush_i = 1'b1;
    #1;
    check1("divflush_we", hi_we_o, 1'b0);
    next_cycle();
    flush_i = 1'b0;
    #1;
    check1("divflush_busy", busy_o, 1'b0);
    check1("divflush_stall", stall_o, 1'b0);
    run_op(2'b00, 32'd7, 32'd6, lat, stalls, rh, rl, rlw);
    check32("after_flush_lat", 32'(lat), 32'd2);
    check32("after_flush_lo", rl, 32'd42);
`else
    next_cycle();
    run_op(2'b10, 32'd9, 32'd3, lat, stalls, rh, rl, rlw);
    check32("nodiv_lat", 32'(lat), 32'd1);
    check32("nodiv_stalls", 32'(stalls), 32'd1);
    check32("nodiv_hi", rh, 32'h0);
    check32("nodiv_lo", rl, 32'h0);

    next_cycle();
    run_op(2'b01, 32'h1234_5678, 32'd2, lat, stalls, rh, rl, rlw);
    check32("refill_hi", rh, 32'h0);
    check32("refill_lo", rl, 32'h2468_ACF0);
`endif

    // Asynchronous reset in the middle of an operation
    next_cycle();
`ifdef HILO_MDU_DIV_EN
    op_valid_i = 1'b1; op_i = 2'b11; src_a_i = 32'd77; src_b_i = 32'd5;
`else
    op_valid_i = 1'b1; op_i = 2'b00; src_a_i = 32'd77; src_b_i = 32'd5;
`endif
    #1;
    next_cycle();
    op_valid_i = 1'b0;
    #1;
    check1("prerst_busy", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check1("midrst_busy", busy_o, 1'b0);
    check1("midrst_stall", stall_o, 1'b0);
    check1("midrst_we", hi_we_o, 1'b0);
    check32("midrst_hi", hi_o, 32'h0);
    check32("midrst_lo", lo_o, 32'h0);
    #3 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle(); #1;
      check1("postrst_we", hi_we_o, 1'b0);
    end
    check1("postrst_busy", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multi-cycle multiply/divide unit that produces HI/LO results for the register file's HI/LO write port and forwarding inputs. It sits in the EX stage and accepts MULT/MULTU/DIV/DIVU operations. It holds the pipeline with a stall request while it works, then issues one HI/LO write pulse carrying the 64-bit result. It is the writer counterpart of the HI/LO read and forward path in the register file.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- op_valid_i  in  1  single-cycle request; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a_i  in  WIDTH  rs operand (multiplicand / dividend).
- src_b_i  in  WIDTH  rt operand (multiplier / divisor).
- flush_i  in  1  abort the current or requesting operation; no write results.
- stall_o  out  1  pipeline hold request.
- busy_o  out  1  unit not in IDLE.
- hi_we_o  out  1  HI write pulse.
- lo_we_o  out  1  LO write pulse.
- hi_o  out  WIDTH  HI result.
- lo_o  out  WIDTH  LO result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **Reset:** state=IDLE. All outputs 0, and so are the internal counter and registers.
- **IDLE:**
  - op_valid_i && !flush_i latches operands and op.
  - MULT/MULTU go to MUL.
  - DIV/DIVU with src_b_i≠0 go to DIV. With src_b_i=0 they go to DONE.
  - op_valid_i && flush_i is ignored.
- **MUL:** registers the 64-bit product; signed for MULT, unsigned for MULTU. Next state DONE.
- **DIV:**
  - Radix-2 restoring division on absolute values; 32 iterations with a 6-bit counter 0..31, then DONE.
  - Quotient is negated when the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (DIV only).
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- **Divide by zero:** HI=dividend, LO=32'hFFFF_FFFF, for both DIV and DIVU.
- **DONE:** hi_we_o=lo_we_o=1 for exactly one cycle, with hi_o=result[63:32] and lo_o=result[31:0]. Next state IDLE.
- **hi_o/lo_o outside DONE:** hold their last value. They are meaningful only while the write enables are high.
- **flush_i:** in any non-IDLE state, the next state is IDLE and no write pulse occurs. If flush_i arrives in DONE, the write pulse is suppressed combinationally.
- **op_valid_i while busy:** ignored. The pipeline is stalled, so this is a protocol error upstream.
- **stall_o:** (state==IDLE && op_valid_i && !flush_i) || state==MUL || state==DIV. It is low in DONE so the consuming instruction advances in the same cycle the write lands.
- **busy_o:** state≠IDLE.

## Timing
- Request accepted in cycle N.
- **MULT/MULTU:** MUL in N+1; write pulse in N+2; stall_o high in cycles N..N+1.
- **DIV/DIVU:** DIV in N+1..N+32; write pulse in N+33; stall_o high in cycles N..N+32.
- **Divide by zero:** write pulse in N+1; stall_o high in N only.
- Back-to-back: a new request is accepted in the cycle after DONE, at the earliest.
- **Reset mid-operation:** immediate return to IDLE with outputs 0; no write pulse.

## Configuration
- **HILO_MDU_DIV_EN defined:** divider present as specified above.
- **HILO_MDU_DIV_EN undefined:** no divider logic.
  - DIV/DIVU go straight to DONE with HI=LO=0.
  - Latency is a write pulse in N+1; stall_o is high in N only.
  - MULT/MULTU are unchanged.

## Structure
- Package hilo_mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - the state enum (IDLE, MUL, DIV, DONE);
  - DIV_ITER = 32.
- Sub-module hilo_mdu_div_core holds the iterative unsigned divider: start, the 6-bit counter, the partial remainder/quotient registers, and a done strobe. It is instantiated only under HILO_MDU_DIV_EN.
- Sign fix-up and the FSM live in the top level.

## Test plan
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> pulse at N+2, HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_o high exactly 2 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> pulse at N+33, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100/7 -> LO=14, HI=2.
- DIV 5 / 0 -> pulse at N+1, HI=5, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU started, flush_i at N+10 -> IDLE at N+11, no write pulse, stall_o low from N+11; a new MULT is accepted at N+11.
- rst asserted mid-DIV (asynchronous, between edges) -> all outputs 0 immediately and busy_o=0; a build without HILO_MDU_DIV_EN gives DIV 9/3 -> HI=LO=0 at N+1.
